// File: rtl/pool_pkg.sv
// Shared constants and width helpers for the pooling_nc datapath.
package pool_pkg;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_ACC   = 1'b1
  } pool_state_e;

  function automatic int pool_dw(input int width_data, input int width_kernel);
    return width_data + width_kernel + 4;
  endfunction

  function automatic int pool_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pool_lane.sv
// One pooling lane: accumulator, max compare / average add, and the final divide.
// The average adder exists only when POOL_AVG_EN is defined.
module pool_lane
  import pool_pkg::*;
#(
  parameter int DW     = 28,
  parameter int CW     = 2,
  parameter int SIGNED = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          fold_i,
  input  logic          mode_i,
  input  logic [DW-1:0] sample_i,
  output logic [DW-1:0] result_o
);

`ifdef POOL_AVG_EN
  localparam int AW = DW + CW;
`else
  localparam int AW = DW;
`endif

  logic [AW-1:0] acc_q;
  logic [AW-1:0] acc_d;
  logic [AW-1:0] sample_ext;
  logic          sample_gt;
  logic [DW-1:0] avg_res;

  always_comb begin
    sample_ext = AW'(sample_i);
    if (SIGNED != 0) begin
      sample_ext = AW'($signed(sample_i));
      sample_gt  = $signed(sample_ext) > $signed(acc_q);
    end else begin
      sample_gt  = sample_ext > acc_q;
    end
  end

  // acc_d is the window value including the current beat; it also feeds the result.
  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = sample_ext;
`ifdef POOL_AVG_EN
    end else if (mode_i == POOL_AVG) begin
      acc_d = acc_q + sample_ext;
`endif
    end else if (sample_gt) begin
      acc_d = sample_ext;
    end
  end

`ifdef POOL_AVG_EN
  // Taking bits [CW +: DW] is the right shift by CW with floor rounding.
  assign avg_res = acc_d[CW +: DW];
`else
  assign avg_res = acc_d[DW-1:0];
`endif

  assign result_o = (mode_i == POOL_AVG) ? avg_res : acc_d[DW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (load_i || fold_i) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/pooling_nc.sv
// Multi-channel non-overlapping 1-D pooling with valid/ready on both sides.
// Define POOL_AVG_EN to build the average-pooling datapath; otherwise max only.
module pooling_nc
  import pool_pkg::*;
#(
  parameter  int WIDTH_DATA   = 16,
  parameter  int WIDTH_KERNEL = 8,
  parameter  int POOL_SIZE    = 4,
  parameter  int CHANNELS     = 4,
  parameter  int SIGNED       = 1,
  localparam int DW           = pool_dw(WIDTH_DATA, WIDTH_KERNEL),
  localparam int CW           = pool_clog2(POOL_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [CHANNELS*DW-1:0] data_i,
  input  logic                   last_i,
  input  logic                   mode_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [CHANNELS*DW-1:0] data_o
);

`ifdef POOL_AVG_EN
  localparam logic AVG_EN = 1'b1;
`else
  localparam logic AVG_EN = 1'b0;
`endif

  // Handshake: a beat moves when valid_i && ready_o; a result moves when
  // valid_o && ready_i. A pending result blocks input unless it is popped this cycle.
  pool_state_e           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  mode_q, mode_d;
  logic                  valid_q, valid_d;
  logic [CHANNELS*DW-1:0] data_q, data_d;
  logic [CHANNELS*DW-1:0] lane_res;
  logic                  accept;
  logic                  complete;
  logic                  load;
  logic                  fold;
  logic                  req_mode;
  logic                  eff_mode;

  assign ready_o  = !valid_q || ready_i;
  assign accept   = valid_i && ready_o;
  assign load     = accept && (state_q == ST_FIRST);
  assign fold     = accept && (state_q == ST_ACC);
  assign complete = accept && (last_i || (cnt_q == CW'(POOL_SIZE - 1)));
  assign req_mode = AVG_EN ? mode_i : POOL_MAX;
  // The first beat of a window uses the live mode; later beats use the captured one.
  assign eff_mode = (state_q == ST_FIRST) ? req_mode : mode_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    pool_lane #(
      .DW    (DW),
      .CW    (CW),
      .SIGNED(SIGNED)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load),
      .fold_i  (fold),
      .mode_i  (eff_mode),
      .sample_i(data_i[k*DW +: DW]),
      .result_o(lane_res[k*DW +: DW])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && ready_i) valid_d = 1'b0;
    if (load) mode_d = req_mode;
    if (accept) begin
      if (complete) begin
        state_d = ST_FIRST;
        cnt_d   = '0;
        valid_d = 1'b1;
        data_d  = lane_res;
      end else begin
        state_d = ST_ACC;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FIRST;
      cnt_q   <= '0;
      mode_q  <= POOL_MAX;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule
